// File: rtl/jk_sequencer.sv
// jk_sequencer
//   Drives one channel of a dual JK flip-flop through a single command
//   (async clear/preset, or a J/K setup followed by generated clock pulses),
//   then reads the selected Q back and reports whether it matched.
//
// Parameters
//   SETTLE : cycles J/K are held before the first clock pulse (>= 1)
//   PULSE  : cycles per CLKx high phase, per low phase, and per PRE/CLR pulse (>= 1)
//
// Ports
//   CLK                 system clock, rising-edge
//   CLR                 asynchronous active-low reset
//   CMD_VALID/CMD_READY command handshake; READY is high only in IDLE
//   CMD_OP              0 HOLD, 1 CLEAR, 2 PRESET, 3 LOAD0, 4 LOAD1, 5 TOGGLE, 6/7 illegal
//   CMD_CH              0 = channel 1, 1 = channel 2
//   CMD_CNT             toggle pulse count (TOGGLE only)
//   DONE / ERR          one-cycle completion pulse; ERR valid with DONE
//   PREx, CLRx          active-low async preset/clear to the flip-flop
//   Jx, Kx, CLKx        data inputs and generated clock (flop captures on CLKx fall)
//   Q1, Q2              flip-flop outputs fed back for checking
module jk_sequencer #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PULSE  = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [2:0] CMD_OP,
  input  logic       CMD_CH,
  input  logic [3:0] CMD_CNT,
  output logic       DONE,
  output logic       ERR,
  output logic       PRE1,
  output logic       CLR1,
  output logic       PRE2,
  output logic       CLR2,
  output logic       J1,
  output logic       K1,
  output logic       J2,
  output logic       K2,
  output logic       CLK1,
  output logic       CLK2,
  input  logic       Q1,
  input  logic       Q2
);

  localparam int unsigned TMAX = (SETTLE > PULSE) ? SETTLE : PULSE;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);
  localparam logic [TW-1:0] PULSE_LD  = TW'(PULSE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ASYNC, S_SETUP, S_CLK_HI, S_CLK_LO, S_CHECK, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_PRESET = 3'd2,
    OP_LOAD0  = 3'd3,
    OP_LOAD1  = 3'd4,
    OP_TOGGLE = 3'd5,
    OP_ILL6   = 3'd6,
    OP_ILL7   = 3'd7
  } op_e;

  state_e          state_q,  state_d;
  op_e             op_q,     op_d;
  logic            ch_q,     ch_d;
  logic [3:0]      cnt_q,    cnt_d;
  logic            q0_q,     q0_d;
  logic [TW-1:0]   timer_q,  timer_d;
  logic [3:0]      pulses_q, pulses_d;
  logic            err_q,    err_d;

  // Selected-channel pin levels before routing to channel 1 or 2.
  logic sel_pre_n, sel_clr_n, sel_j, sel_k, sel_clk;
  logic q_sel, exp_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= S_IDLE;
      op_q     <= OP_HOLD;
      ch_q     <= 1'b0;
      cnt_q    <= '0;
      q0_q     <= 1'b0;
      timer_q  <= '0;
      pulses_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      q0_q     <= q0_d;
      timer_q  <= timer_d;
      pulses_q <= pulses_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    q_sel = ch_q ? Q2 : Q1;
    case (op_q)
      OP_CLEAR:  exp_q = 1'b0;
      OP_PRESET: exp_q = 1'b1;
      OP_LOAD0:  exp_q = 1'b0;
      OP_LOAD1:  exp_q = 1'b1;
      OP_HOLD:   exp_q = q0_q;
      OP_TOGGLE: exp_q = q0_q ^ cnt_q[0];
      default:   exp_q = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    q0_d      = q0_q;
    timer_d   = timer_q;
    pulses_d  = pulses_q;
    err_d     = err_q;
    sel_pre_n = 1'b1;
    sel_clr_n = 1'b1;
    sel_j     = 1'b0;
    sel_k     = 1'b0;
    sel_clk   = 1'b0;
    CMD_READY = 1'b0;
    DONE      = 1'b0;
    ERR       = 1'b0;

    // J/K are held for the whole clocked window, SETUP through CLK_LO.
    if (state_q == S_SETUP || state_q == S_CLK_HI || state_q == S_CLK_LO) begin
      case (op_q)
        OP_LOAD0:  begin sel_j = 1'b0; sel_k = 1'b1; end
        OP_LOAD1:  begin sel_j = 1'b1; sel_k = 1'b0; end
        OP_TOGGLE: begin sel_j = 1'b1; sel_k = 1'b1; end
        default:   begin sel_j = 1'b0; sel_k = 1'b0; end
      endcase
    end

    case (state_q)
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          op_d  = op_e'(CMD_OP);
          ch_d  = CMD_CH;
          cnt_d = CMD_CNT;
          q0_d  = CMD_CH ? Q2 : Q1;
          err_d = 1'b0;
          case (op_e'(CMD_OP))
            OP_CLEAR, OP_PRESET: begin
              state_d = S_ASYNC;
              timer_d = PULSE_LD;
            end
            OP_HOLD, OP_LOAD0, OP_LOAD1: begin
              state_d  = S_SETUP;
              timer_d  = SETTLE_LD;
              pulses_d = 4'd1;
            end
            OP_TOGGLE: begin
              state_d  = S_SETUP;
              timer_d  = SETTLE_LD;
              pulses_d = CMD_CNT;
            end
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_ASYNC: begin
        if (op_q == OP_CLEAR) sel_clr_n = 1'b0;
        else                  sel_pre_n = 1'b0;
        if (timer_q == '0) state_d = S_CHECK;
        else               timer_d = timer_q - 1'b1;
      end
      S_SETUP: begin
        if (timer_q == '0) begin
          if (pulses_q == 4'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_CLK_HI;
            timer_d = PULSE_LD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_CLK_HI: begin
        sel_clk = 1'b1;
        if (timer_q == '0) begin
          state_d = S_CLK_LO;
          timer_d = PULSE_LD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_CLK_LO: begin
        if (timer_q == '0) begin
          pulses_d = pulses_q - 4'd1;
          if (pulses_q == 4'd1) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_CLK_HI;
            timer_d = PULSE_LD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_CHECK: begin
        err_d   = (q_sel != exp_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        DONE    = 1'b1;
        ERR     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    PRE1 = ch_q ? 1'b1 : sel_pre_n;
    CLR1 = ch_q ? 1'b1 : sel_clr_n;
    J1   = ch_q ? 1'b0 : sel_j;
    K1   = ch_q ? 1'b0 : sel_k;
    CLK1 = ch_q ? 1'b0 : sel_clk;
    PRE2 = ch_q ? sel_pre_n : 1'b1;
    CLR2 = ch_q ? sel_clr_n : 1'b1;
    J2   = ch_q ? sel_j : 1'b0;
    K2   = ch_q ? sel_k : 1'b0;
    CLK2 = ch_q ? sel_clk : 1'b0;
  end

endmodule

// File: tb/tb_jk_sequencer.sv
// tb_jk_sequencer
//   Drives jk_sequencer against a behavioural dual JK flip-flop (falling-edge
//   capture, async active-low preset/clear) and checks latency, ERR, final Q
//   and pin activity against hand-computed vectors.
module tb_jk_sequencer;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned PULSE  = 2;
  localparam int MAXC = 60;

  logic       CLK, CLR, CMD_VALID, CMD_READY, CMD_CH, DONE, ERR;
  logic [2:0] CMD_OP;
  logic [3:0] CMD_CNT;
  logic       PRE1, CLR1, PRE2, CLR2, J1, K1, J2, K2, CLK1, CLK2, Q1, Q2;
  logic       ff1, ff2, stuck1;

  int checks;
  int errors;

  logic tr_clk [MAXC+1];
  logic tr_j   [MAXC+1];
  logic tr_k   [MAXC+1];
  logic tr_pre [MAXC+1];
  logic tr_clr [MAXC+1];
  logic tr_rdy [MAXC+1];
  logic tr_done[MAXC+1];
  int   rises;
  bit   other_act, sel_act;

  jk_sequencer #(.SETTLE(SETTLE), .PULSE(PULSE)) dut (
    .CLK(CLK), .CLR(CLR), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_CH(CMD_CH), .CMD_CNT(CMD_CNT),
    .DONE(DONE), .ERR(ERR),
    .PRE1(PRE1), .CLR1(CLR1), .PRE2(PRE2), .CLR2(CLR2),
    .J1(J1), .K1(K1), .J2(J2), .K2(K2), .CLK1(CLK1), .CLK2(CLK2),
    .Q1(Q1), .Q2(Q2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK1 or negedge PRE1 or negedge CLR1) begin
    if (!CLR1)      ff1 <= 1'b0;
    else if (!PRE1) ff1 <= 1'b1;
    else case ({J1, K1})
      2'b01:   ff1 <= 1'b0;
      2'b10:   ff1 <= 1'b1;
      2'b11:   ff1 <= ~ff1;
      default: ;
    endcase
  end

  always @(negedge CLK2 or negedge PRE2 or negedge CLR2) begin
    if (!CLR2)      ff2 <= 1'b0;
    else if (!PRE2) ff2 <= 1'b1;
    else case ({J2, K2})
      2'b01:   ff2 <= 1'b0;
      2'b10:   ff2 <= 1'b1;
      2'b11:   ff2 <= ~ff2;
      default: ;
    endcase
  end

  assign Q1 = stuck1 ? 1'b0 : ff1;
  assign Q2 = ff2;

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Issue one command and trace the selected channel's pins each cycle
  // (cycle k = k-th cycle after the accept edge) until DONE.
  // With poke set, a CLEAR on the other channel is requested while busy.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic ch,
                         input logic [3:0] cnt, input bit poke,
                         output int lat, output logic err);
    logic sclk, sj, sk, spre, sclr, prev;
    @(negedge CLK);
    chk({tag, "_ready"}, CMD_READY, 1);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_CH = ch; CMD_CNT = cnt;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    if (poke) begin CMD_OP = 3'b001; CMD_CH = ~ch; end
    lat = -1; err = 1'b0; rises = 0; other_act = 0; sel_act = 0; prev = 1'b0;
    for (int k = 0; k <= MAXC; k++) begin
      tr_clk[k] = 0; tr_j[k] = 0; tr_k[k] = 0; tr_pre[k] = 0;
      tr_clr[k] = 0; tr_rdy[k] = 0; tr_done[k] = 0;
    end
    for (int k = 1; k <= MAXC && lat < 0; k++) begin
      @(negedge CLK);
      sclk = ch ? CLK2 : CLK1;  sj   = ch ? J2 : J1;   sk = ch ? K2 : K1;
      spre = ch ? PRE2 : PRE1;  sclr = ch ? CLR2 : CLR1;
      tr_clk[k] = sclk; tr_j[k] = sj; tr_k[k] = sk; tr_pre[k] = spre;
      tr_clr[k] = sclr; tr_rdy[k] = CMD_READY; tr_done[k] = DONE;
      if (sclk && !prev) rises++;
      prev = sclk;
      if (sclk || sj || sk || !spre || !sclr) sel_act = 1;
      if (ch ? (CLK1 || J1 || K1 || !PRE1 || !CLR1)
             : (CLK2 || J2 || K2 || !PRE2 || !CLR2)) other_act = 1;
      if (DONE) begin lat = k; err = ERR; end
      CMD_VALID = poke && (k < 5);
    end
    CMD_VALID = 1'b0;
    if (lat < 0) chk({tag, "_done_seen"}, 0, 1);
  endtask

  typedef struct {
    logic [2:0] op;
    logic       ch;
    logic [3:0] cnt;
    int         lat;
    logic       err;
    logic       q;
    int         rises;
  } vec_t;

  vec_t vt[14];

  initial begin
    int   lat, dcount;
    logic err;
    string nm;

    checks = 0; errors = 0; stuck1 = 1'b0;
    CLR = 1'b0; CMD_VALID = 1'b0; CMD_OP = '0; CMD_CH = 1'b0; CMD_CNT = '0;

    // op, ch, cnt, latency, err, final Q, CLK rises -- Q tracked by hand
    vt[0]  = '{3'b001, 1'b0, 4'd0, 4,  1'b0, 1'b0, 0};  // CLEAR ch1
    vt[1]  = '{3'b001, 1'b1, 4'd0, 4,  1'b0, 1'b0, 0};  // CLEAR ch2
    vt[2]  = '{3'b100, 1'b0, 4'd0, 8,  1'b0, 1'b1, 1};  // LOAD1 ch1
    vt[3]  = '{3'b011, 1'b0, 4'd0, 8,  1'b0, 1'b0, 1};  // LOAD0 ch1
    vt[4]  = '{3'b010, 1'b1, 4'd0, 4,  1'b0, 1'b1, 0};  // PRESET ch2
    vt[5]  = '{3'b101, 1'b0, 4'd3, 16, 1'b0, 1'b1, 3};  // TOGGLE x3 ch1 0->1
    vt[6]  = '{3'b101, 1'b0, 4'd2, 12, 1'b0, 1'b1, 2};  // TOGGLE x2 ch1 1->1
    vt[7]  = '{3'b101, 1'b0, 4'd0, 4,  1'b0, 1'b1, 0};  // TOGGLE x0
    vt[8]  = '{3'b000, 1'b0, 4'd0, 8,  1'b0, 1'b1, 1};  // HOLD ch1
    vt[9]  = '{3'b011, 1'b1, 4'd5, 8,  1'b0, 1'b0, 1};  // LOAD0 ch2, cnt ignored
    vt[10] = '{3'b101, 1'b1, 4'd1, 8,  1'b0, 1'b1, 1};  // TOGGLE x1 ch2 0->1
    vt[11] = '{3'b110, 1'b0, 4'd0, 1,  1'b1, 1'b1, 0};  // illegal 110
    vt[12] = '{3'b111, 1'b1, 4'd0, 1,  1'b1, 1'b1, 0};  // illegal 111
    vt[13] = '{3'b000, 1'b0, 4'd7, 8,  1'b0, 1'b1, 1};  // HOLD, cnt ignored

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_ready", CMD_READY, 1);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_pre_clr", {PRE1, CLR1, PRE2, CLR2}, 4'b1111);
    chk("rst_jk_clk", {J1, K1, J2, K2, CLK1, CLK2}, 6'b000000);
    CLR = 1'b1;

    for (int i = 0; i < 14; i++) begin
      nm = $sformatf("v%0d", i);
      run_cmd(nm, vt[i].op, vt[i].ch, vt[i].cnt, 1'b0, lat, err);
      chk({nm, "_latency"}, lat, vt[i].lat);
      chk({nm, "_err"}, err, vt[i].err);
      chk({nm, "_q"}, vt[i].ch ? Q2 : Q1, vt[i].q);
      chk({nm, "_clk_rises"}, rises, vt[i].rises);
      chk({nm, "_other_idle"}, other_act, 0);
      if (vt[i].op > 3'd5) chk({nm, "_no_pins"}, sel_act, 0);
    end

    // CLEAR ch1 cycle trace
    run_cmd("clr_tr", 3'b001, 1'b0, 4'd0, 1'b0, lat, err);
    chk("clr_tr_latency", lat, 4);
    chk("clr_tr_err", err, 0);
    chk("clr_tr_other_idle", other_act, 0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("clr_tr_clr1_c%0d", k), tr_clr[k], (k <= 2) ? 0 : 1);
      chk($sformatf("clr_tr_pre1_c%0d", k), tr_pre[k], 1);
      chk($sformatf("clr_tr_ready_c%0d", k), tr_rdy[k], 0);
      chk($sformatf("clr_tr_done_c%0d", k), tr_done[k], (k == 4) ? 1 : 0);
    end

    // LOAD1 ch1 from Q1=0 cycle trace
    run_cmd("ld1_tr", 3'b100, 1'b0, 4'd0, 1'b0, lat, err);
    chk("ld1_tr_latency", lat, 8);
    chk("ld1_tr_err", err, 0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("ld1_tr_j1_c%0d", k), tr_j[k], (k <= 6) ? 1 : 0);
      chk($sformatf("ld1_tr_k1_c%0d", k), tr_k[k], 0);
      chk($sformatf("ld1_tr_clk1_c%0d", k), tr_clk[k], (k == 3 || k == 4) ? 1 : 0);
    end

    // PRESET ch2, then 11 HOLDs
    run_cmd("pre2", 3'b010, 1'b1, 4'd0, 1'b0, lat, err);
    chk("pre2_err", err, 0);
    for (int i = 0; i < 11; i++) begin
      nm = $sformatf("hold%0d", i);
      run_cmd(nm, 3'b000, 1'b1, 4'd0, 1'b0, lat, err);
      chk({nm, "_err"}, err, 0);
      chk({nm, "_q2"}, Q2, 1);
    end

    // TOGGLE x3 with Q1 stuck at 0
    run_cmd("stk_clr", 3'b001, 1'b0, 4'd0, 1'b0, lat, err);
    stuck1 = 1'b1;
    run_cmd("stuck", 3'b101, 1'b0, 4'd3, 1'b0, lat, err);
    chk("stuck_latency", lat, 16);
    chk("stuck_clk_rises", rises, 3);
    chk("stuck_err", err, 1);
    stuck1 = 1'b0;

    // CMD_VALID while busy must be ignored
    run_cmd("busy", 3'b011, 1'b0, 4'd0, 1'b1, lat, err);
    chk("busy_latency", lat, 8);
    chk("busy_err", err, 0);
    chk("busy_other_idle", other_act, 0);
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (DONE || !CLR2) dcount++;
    end
    chk("busy_no_late_cmd", dcount, 0);

    // CLR pulsed during CLK_HI of a TOGGLE
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_OP = 3'b101; CMD_CH = 1'b0; CMD_CNT = 4'd3;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    for (int k = 0; k < 20 && !CLK1; k++) @(negedge CLK);
    chk("abort_clkhi_seen", CLK1, 1);
    CLR = 1'b0;
    #1;
    chk("abort_clk1", CLK1, 0);
    chk("abort_jk1", {J1, K1}, 2'b00);
    chk("abort_ready", CMD_READY, 1);
    chk("abort_done", DONE, 0);
    repeat (2) @(negedge CLK);
    CLR = 1'b1;
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (DONE) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    run_cmd("after", 3'b100, 1'b0, 4'd0, 1'b0, lat, err);
    chk("after_latency", lat, 8);
    chk("after_err", err, 0);
    chk("after_q1", Q1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
